// File: rtl/mem_ctrl.sv
// Byte-serial owner of the external RAM/IO port. Turns ICache line fills and
// LSB byte/half/word accesses into per-byte cycles with a one-cycle done pulse.
module mem_ctrl #(
  parameter int          LINE_BYTES = 64,
  parameter int          ADDR_W     = 32,
  parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    if_en,
  input  logic [ADDR_W-1:0]       if_pc,
  output logic [8*LINE_BYTES-1:0] if_data,
  output logic                    if_done,
  input  logic                    lsb_en,
  input  logic                    lsb_wr,
  input  logic [ADDR_W-1:0]       lsb_addr,
  input  logic [1:0]              lsb_len,
  input  logic [31:0]             lsb_w_data,
  output logic [31:0]             lsb_r_data,
  output logic                    lsb_done
);
  localparam int CW = $clog2(LINE_BYTES);

  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, GAP} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n, cnt_inc, last, last_n;
  logic [ADDR_W-1:0]       base, base_n, mem_a_n;
  logic [31:0]             wdata, wdata_n, rmask, lsb_r_data_n;
  logic                    wr_q, wr_n, if_done_n, lsb_done_n;
  logic                    last_grant, last_grant_n, pick_lsb, stall;
  logic [7:0]              dout_n;
  logic [8*LINE_BYTES-1:0] line_buf, buf_n, asm_line, if_data_n;

  // IO writes wait for buffer space; the write strobe is suppressed meanwhile
  assign stall  = (state == LS_WR) && (base[17:16] == IO_BASE_HI) && io_buffer_full;
  assign mem_wr = wr_q & rdy & rst & ~stall;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_n       = last;
    base_n       = base;
    wdata_n      = wdata;
    mem_a_n      = mem_a;
    wr_n         = wr_q;
    dout_n       = mem_dout;
    buf_n        = line_buf;
    if_data_n    = if_data;
    lsb_r_data_n = lsb_r_data;
    if_done_n    = 1'b0;
    lsb_done_n   = 1'b0;
    last_grant_n = last_grant;
    pick_lsb     = 1'b0;
    cnt_inc      = cnt + 1'b1;
    asm_line     = line_buf;
    asm_line[8*cnt +: 8] = mem_din;
    rmask = (last == CW'(0)) ? 32'h0000_00FF :
            (last == CW'(1)) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    case (state)
      IDLE: begin
        if (!rollback && (if_en || lsb_en)) begin
          // last_grant: 0 = IF, 1 = LSB; on contention the other side wins
          pick_lsb     = lsb_en && (!if_en || !last_grant);
          last_grant_n = pick_lsb;
          cnt_n        = '0;
          if (pick_lsb) begin
            base_n  = lsb_addr;
            wdata_n = lsb_w_data;
            mem_a_n = lsb_addr;
            wr_n    = lsb_wr;
            dout_n  = lsb_w_data[7:0];
            last_n  = (lsb_len == 2'b00) ? CW'(0) : (lsb_len == 2'b01) ? CW'(1) : CW'(3);
            state_n = lsb_wr ? LS_WR : LS_RD;
          end else begin
            base_n  = if_pc;
            mem_a_n = if_pc;
            wr_n    = 1'b0;
            last_n  = CW'(LINE_BYTES-1);
            state_n = IF_RD;
          end
        end
      end
      IF_RD, LS_RD: begin
        if (rollback) begin
          state_n = IDLE;
          mem_a_n = '0;
          wr_n    = 1'b0;
        end else begin
          buf_n = asm_line;
          if (cnt == last) begin
            state_n = GAP;
            mem_a_n = '0;
            if (state == IF_RD) begin
              if_data_n = asm_line;
              if_done_n = 1'b1;
            end else begin
              lsb_r_data_n = asm_line[31:0] & rmask;
              lsb_done_n   = 1'b1;
            end
          end else begin
            cnt_n   = cnt_inc;
            mem_a_n = base + ADDR_W'(cnt_inc);
          end
        end
      end
      LS_WR: begin
        if (!stall) begin
          if (cnt == last) begin
            state_n    = GAP;
            mem_a_n    = '0;
            wr_n       = 1'b0;
            lsb_done_n = 1'b1;
          end else begin
            cnt_n   = cnt_inc;
            mem_a_n = base + ADDR_W'(cnt_inc);
            dout_n  = wdata[8*cnt_inc[1:0] +: 8];
          end
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= '0;
      base       <= '0;
      wdata      <= '0;
      mem_a      <= '0;
      wr_q       <= 1'b0;
      mem_dout   <= '0;
      line_buf   <= '0;
      if_data    <= '0;
      lsb_r_data <= '0;
      if_done    <= 1'b0;
      lsb_done   <= 1'b0;
      last_grant <= 1'b0;
    end else if (rdy) begin
      state      <= state_n;
      cnt        <= cnt_n;
      last       <= last_n;
      base       <= base_n;
      wdata      <= wdata_n;
      mem_a      <= mem_a_n;
      wr_q       <= wr_n;
      mem_dout   <= dout_n;
      line_buf   <= buf_n;
      if_data    <= if_data_n;
      lsb_r_data <= lsb_r_data_n;
      if_done    <= if_done_n;
      lsb_done   <= lsb_done_n;
      last_grant <= last_grant_n;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model with a write log, an LSB
// vector table, and hand sequences for contention, IO stall, rollback, rdy and reset.
module tb_mem_ctrl;
  logic         clk, rst, rdy, rollback, io_buffer_full;
  logic [7:0]   mem_din, mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         if_en, if_done, lsb_en, lsb_wr, lsb_done;
  logic [31:0]  if_pc, lsb_addr, lsb_w_data, lsb_r_data;
  logic [1:0]   lsb_len;
  logic [511:0] if_data, exp_line;

  int checks = 0, errors = 0;
  int if_cnt = 0, lsb_cnt = 0;
  logic [7:0]  ram [0:4095];
  logic [31:0] wl_a [$];
  logic [7:0]  wl_d [$];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_pc(if_pc), .if_data(if_data), .if_done(if_done),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_r_data(lsb_r_data), .lsb_done(lsb_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // RAM: combinational read, write on the edge that sees mem_wr
  assign mem_din = ram[mem_a[11:0]];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    for (int k = 0; k < 64; k++) ram[12'h040 + k] = k[7:0];
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    ram[12'h204] = 8'h5A;
    forever begin
      @(posedge clk);
      if (mem_wr) begin
        ram[mem_a[11:0]] = mem_dout;
        wl_a.push_back(mem_a);
        wl_d.push_back(mem_dout);
      end
    end
  end

  always @(posedge clk) begin
    if (if_done)  if_cnt  <= if_cnt + 1;
    if (lsb_done) lsb_cnt <= lsb_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one LSB request just after an edge; lat = samples until done (N+1)
  task automatic do_lsb(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
    lsb_wr = wr; lsb_len = len; lsb_addr = addr; lsb_w_data = wd; lsb_en = 1;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (lsb_done) begin lat = n; break; end
    end
    lsb_en = 0;
    rd = lsb_r_data;
    tick();
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;
  vec_t vt [7];

  initial begin
    int lat, base_sz, bad, t1, t2, t3, nd, ic0, lc0;
    logic [31:0] rd;
    logic [1:0]  order [3];

    vt[0] = '{1'b0, 2'b11, 32'h100, 32'h0,        32'h1234_5678, 5};
    vt[1] = '{1'b0, 2'b00, 32'h103, 32'h0,        32'h0000_0012, 2};
    vt[2] = '{1'b0, 2'b01, 32'h101, 32'h0,        32'h0000_3456, 3};
    vt[3] = '{1'b1, 2'b01, 32'h202, 32'hAABBCCDD, 32'h0000_3456, 3};
    vt[4] = '{1'b1, 2'b11, 32'h400, 32'hDEADBEEF, 32'h0000_3456, 5};
    vt[5] = '{1'b0, 2'b10, 32'h400, 32'h0,        32'hDEAD_BEEF, 5};
    vt[6] = '{1'b0, 2'b00, 32'h402, 32'h0,        32'h0000_00AD, 2};
    for (int k = 0; k < 64; k++) exp_line[8*k +: 8] = k[7:0];

    rst = 0; rdy = 1; rollback = 0; io_buffer_full = 0;
    if_en = 0; if_pc = 32'h40; lsb_en = 0; lsb_wr = 0; lsb_addr = 0; lsb_len = 0; lsb_w_data = 0;
    tick(); tick();
    chk("reset mem_a", mem_a, 0);
    chk("reset mem_wr", mem_wr, 0);
    chk("reset mem_dout", mem_dout, 0);
    chk("reset dones", {if_done, lsb_done}, 0);
    chk("reset lsb_r_data", lsb_r_data, 0);
    chk("reset if_data", (if_data == 0), 1);
    rst = 1;

    // Contention from reset: both held high, grants must go LSB, IF, LSB
    if_pc = 32'h40; lsb_wr = 0; lsb_len = 2'b00; lsb_addr = 32'h103;
    if_en = 1; lsb_en = 1;
    nd = 0; t1 = 0; t2 = 0; t3 = 0;
    for (int n = 1; n <= 400 && nd < 3; n++) begin
      tick();
      if (if_done || lsb_done) begin
        order[nd] = {if_done, lsb_done};
        if (nd == 0) begin t1 = n; chk("contention lsb data", lsb_r_data, 32'h12); end
        if (nd == 1) begin t2 = n; chk("contention line data", (if_data == exp_line), 1); end
        if (nd == 2) t3 = n;
        nd++;
      end
    end
    if_en = 0; lsb_en = 0;
    tick();
    chk("contention done count", nd, 3);
    chk("contention order", {order[0], order[1], order[2]}, {2'b01, 2'b10, 2'b01});
    chk("contention first lat", t1, 2);
    chk("contention IF spacing", t2 - t1, 66);
    chk("contention LSB spacing", t3 - t2, 3);

    // Line fill: one address per cycle, done exactly 64 cycles after accept
    if_pc = 32'h40; if_en = 1; bad = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (k == 0) if_en = 1;
      if (mem_a !== 32'h40 + k || if_done !== 1'b0 || mem_wr !== 1'b0) bad++;
    end
    chk("fill address walk", bad, 0);
    tick();
    chk("fill done", if_done, 1);
    chk("fill mem_a after done", mem_a, 0);
    chk("fill data", (if_data == exp_line), 1);
    if_en = 0;
    tick();
    chk("fill done one cycle", if_done, 0);

    // LSB vector table
    for (int v = 0; v < 7; v++) begin
      base_sz = wl_a.size();
      do_lsb(vt[v].wr, vt[v].len, vt[v].addr, vt[v].wdata, lat, rd);
      chk($sformatf("vec%0d latency", v), lat, vt[v].exp_lat);
      chk($sformatf("vec%0d r_data", v), rd, vt[v].exp_rd);
      if (vt[v].wr) begin
        chk($sformatf("vec%0d write count", v), wl_a.size() - base_sz, vt[v].exp_lat - 1);
        bad = 0;
        for (int k = 0; k < vt[v].exp_lat - 1 && base_sz + k < wl_a.size(); k++)
          if (wl_a[base_sz+k] !== vt[v].addr + k || wl_d[base_sz+k] !== vt[v].wdata[8*k +: 8]) bad++;
        chk($sformatf("vec%0d write bytes", v), bad, 0);
      end
    end
    chk("half store neighbour", ram[12'h204], 8'h5A);

    // IO stall: buffer full for 5 cycles after accept
    io_buffer_full = 1; base_sz = wl_a.size(); lc0 = lsb_cnt;
    lsb_wr = 1; lsb_len = 2'b00; lsb_addr = 32'h30000; lsb_w_data = 32'h41; lsb_en = 1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_wr !== 1'b0 || lsb_done !== 1'b0) bad++;
    end
    chk("io stall no strobe", bad, 0);
    tick();
    io_buffer_full = 0;
    #1;
    chk("io resume strobe", {mem_wr, mem_dout}, {1'b1, 8'h41});
    chk("io resume addr", mem_a, 32'h30000);
    chk("io no early write", wl_a.size() - base_sz, 0);
    tick();
    chk("io done", lsb_done, 1);
    lsb_en = 0;
    chk("io write logged", wl_a.size() - base_sz, 1);
    if (wl_a.size() > base_sz) chk("io write byte", {wl_a[base_sz], wl_d[base_sz]}, {32'h30000, 8'h41});
    tick();

    // Rollback during line fill at byte 10
    ic0 = if_cnt; if_pc = 32'h40; if_en = 1;
    for (int k = 0; k <= 10; k++) tick();
    chk("rollback pre addr", mem_a, 32'h4A);
    rollback = 1;
    tick();
    rollback = 0; if_en = 0;
    chk("rollback mem_a", mem_a, 0);
    chk("rollback mem_wr", mem_wr, 0);
    lsb_wr = 0; lsb_len = 2'b00; lsb_addr = 32'h101; lsb_en = 1;
    tick();
    chk("post-rollback accept", mem_a, 32'h101);
    tick();
    chk("post-rollback done", {lsb_done, lsb_r_data}, {1'b1, 32'h56});
    lsb_en = 0;
    tick();
    chk("rollback no if_done", if_cnt - ic0, 0);

    // Rollback in IDLE blocks acceptance for that cycle
    lsb_addr = 32'h103; lsb_en = 1; rollback = 1;
    tick();
    chk("idle rollback no accept", mem_a, 0);
    rollback = 0;
    tick();
    chk("idle accept after rollback", mem_a, 32'h103);
    tick();
    chk("idle rollback load", {lsb_done, lsb_r_data}, {1'b1, 32'h12});
    lsb_en = 0;
    tick();

    // rdy low for 3 cycles mid-load delays done by exactly 3 cycles
    lsb_wr = 0; lsb_len = 2'b11; lsb_addr = 32'h100; lsb_en = 1; lat = -1;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (n == 2) rdy = 0;
      if (n == 5) rdy = 1;
      if (lsb_done) begin lat = n; break; end
    end
    lsb_en = 0;
    chk("rdy stall latency", lat, 8);
    chk("rdy stall data", lsb_r_data, 32'h1234_5678);
    tick();

    // Reset mid-store: no done, no writes after reset
    base_sz = wl_a.size(); lc0 = lsb_cnt;
    lsb_wr = 1; lsb_len = 2'b11; lsb_addr = 32'h500; lsb_w_data = 32'h11223344; lsb_en = 1;
    tick(); tick(); tick();
    rst = 0; lsb_en = 0;
    tick();
    rst = 1;
    tick(); tick(); tick();
    chk("reset mid-store writes", wl_a.size() - base_sz, 2);
    chk("reset mid-store no done", lsb_cnt - lc0, 0);
    chk("reset mid-store idle", {mem_wr, mem_a}, 33'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
